// File: rtl/uart_transmitter.sv
// uart_transmitter: FIFO-buffered serial transmitter.
// Frame: start(0), 8 data bits LSB first, parity slot, stop(1), each CLKS_PER_BIT clocks.
// Optional feature macro UART_TX_PARITY_EN: parity slot carries even parity of the byte;
// when undefined the parity slot is a constant 0.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 864,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       ready,
  output logic       Tx_D,
  output logic       busy,
  output logic       overflow
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   count, count_n;
  logic               full, empty, wr, pop;
  logic [7:0]         head;
  logic               head_par;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [2:0]         idx, idx_n;
  logic [7:0]         shift, shift_n;
  logic               par, par_n;
  logic               tx_n;
  logic               cnt_end;

  assign full    = (count == (FIFO_AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign wr      = data_valid && !full;
  assign head    = mem[rptr];
  assign cnt_end = (cnt == CW'(CLKS_PER_BIT - 1));
  assign busy    = (state != IDLE);

`ifdef UART_TX_PARITY_EN
  assign head_par = ^head;
`else
  assign head_par = 1'b0;
`endif

  // FIFO storage: no reset needed, validity is tracked by count
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= data_in;
  end

  // next occupancy, used for count and the registered ready flag
  always_comb begin
    count_n = count;
    case ({wr, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  // FIFO pointers, occupancy, ready and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      ready    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count_n;
      ready <= (count_n != (FIFO_AW+1)'(FIFO_DEPTH));
      if (data_valid && full) overflow <= 1'b1;
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      par   <= 1'b0;
      Tx_D  <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      par   <= par_n;
      Tx_D  <= tx_n;
    end
  end

  // next-state and line value; a pop loads the head byte and its parity together
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    par_n   = par;
    tx_n    = Tx_D;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_n  = 1'b1;
        cnt_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          par_n   = head_par;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        cnt_n = cnt + 1'b1;
        if (cnt_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = shift[0];
          state_n = DATA;
        end
      end
      DATA: begin
        cnt_n = cnt + 1'b1;
        if (cnt_end) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            tx_n    = par;
            state_n = PARITY;
          end else begin
            shift_n = shift >> 1;
            idx_n   = idx + 1'b1;
            tx_n    = shift[1];
          end
        end
      end
      PARITY: begin
        cnt_n = cnt + 1'b1;
        if (cnt_end) begin
          cnt_n   = '0;
          tx_n    = 1'b1;
          state_n = STOP;
        end
      end
      STOP: begin
        cnt_n = cnt + 1'b1;
        if (cnt_end) begin
          cnt_n = '0;
          if (!empty) begin
            // back-to-back frame: no idle gap
            pop     = 1'b1;
            shift_n = head;
            par_n   = head_par;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end
endmodule
